// File: rtl/condicionador_botoes.sv
// Button conditioner: synchronizes and debounces 7 raw buttons, then classifies
// them as idle / single press / multi-press and emits a one-cycle press pulse.
module condicionador_botoes #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] botoes_raw,
  input  logic       habilita,
  output logic [6:0] botoes,
  output logic [2:0] nota,
  output logic       tem_botao_pressionado,
  output logic       pulso_jogada,
  output logic       multiplo,
  output logic [1:0] db_estado
);

  localparam logic [1:0]  OCIOSO      = 2'b00;
  localparam logic [1:0]  PRESSIONADO = 2'b01;
  localparam logic [1:0]  MULTIPLO    = 2'b10;
  localparam logic [15:0] DEB_LAST    = 16'(DEBOUNCE_CYCLES - 1);

  logic [6:0] sync1_reg;
  logic [6:0] sync2_reg;
  logic [6:0] deb;
  logic [1:0] state_reg;
  logic [1:0] state_next;
  logic [6:0] botoes_reg;
  logic [2:0] nota_reg;
  logic [2:0] nota_enc;
  logic       pulso_reg;
  logic [2:0] pop;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= botoes_raw;
      sync2_reg <= sync1_reg;
    end
  end

  // Each bit needs DEBOUNCE_CYCLES consecutive disagreeing samples to flip.
  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_deb
      logic [15:0] cnt_reg;
      logic        deb_bit_reg;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          cnt_reg     <= '0;
          deb_bit_reg <= 1'b0;
        end else if (sync2_reg[gi] == deb_bit_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == DEB_LAST) begin
          cnt_reg     <= '0;
          deb_bit_reg <= ~deb_bit_reg;
        end else begin
          cnt_reg <= cnt_reg + 16'd1;
        end
      end

      assign deb[gi] = deb_bit_reg;
    end
  endgenerate

  always_comb begin
    pop      = '0;
    nota_enc = '0;
    for (int i = 0; i < 7; i++) begin
      pop = pop + {2'b00, deb[i]};
      if (deb[i]) nota_enc = 3'(i + 1);
    end
  end

  // botoes_reg holds the accepted key while pressed, so a differing single bit is a swap.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      OCIOSO: begin
        if (pop == 3'd1)      state_next = PRESSIONADO;
        else if (pop >= 3'd2) state_next = MULTIPLO;
      end
      PRESSIONADO: begin
        if (pop == 3'd0)             state_next = OCIOSO;
        else if (pop >= 3'd2)        state_next = MULTIPLO;
        else if (deb != botoes_reg)  state_next = MULTIPLO;
      end
      MULTIPLO: begin
        if (pop == 3'd0) state_next = OCIOSO;
      end
      default: state_next = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg  <= OCIOSO;
      botoes_reg <= '0;
      nota_reg   <= '0;
      pulso_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      botoes_reg <= (state_next == PRESSIONADO) ? deb : 7'd0;
      nota_reg   <= (state_next == PRESSIONADO) ? nota_enc : 3'd0;
      pulso_reg  <= (state_reg == OCIOSO) && (state_next == PRESSIONADO) && habilita;
    end
  end

  assign botoes                = botoes_reg;
  assign nota                  = nota_reg;
  assign pulso_jogada          = pulso_reg;
  assign tem_botao_pressionado = |deb;
  assign multiplo              = (state_reg == MULTIPLO);
  assign db_estado             = state_reg;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Scoreboard bench for condicionador_botoes: a window-based reference model pushes
// expected outputs per clock edge; an independent monitor pops and compares.
module tb_condicionador_botoes;

  localparam int D = 4;

  typedef struct packed {
    logic [6:0] botoes;
    logic [2:0] nota;
    logic       tem;
    logic       pulso;
    logic       multi;
    logic [1:0] estado;
  } out_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] botoes_raw = '0;
  logic       habilita = 1'b1;
  logic [6:0] botoes;
  logic [2:0] nota;
  logic       tem_botao_pressionado;
  logic       pulso_jogada;
  logic       multiplo;
  logic [1:0] db_estado;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  bit done   = 0;

  out_t exp_q[$];

  // Reference model state: raw-sample history, debounced level, accepted key, state.
  logic [6:0] m_hist[$];
  logic [6:0] m_deb;
  logic [6:0] m_key;
  int         m_state;

  condicionador_botoes #(.DEBOUNCE_CYCLES(D)) dut (
    .clock(clock),
    .reset(reset),
    .botoes_raw(botoes_raw),
    .habilita(habilita),
    .botoes(botoes),
    .nota(nota),
    .tem_botao_pressionado(tem_botao_pressionado),
    .pulso_jogada(pulso_jogada),
    .multiplo(multiplo),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  function automatic out_t actual();
    out_t a;
    a.botoes = botoes;
    a.nota   = nota;
    a.tem    = tem_botao_pressionado;
    a.pulso  = pulso_jogada;
    a.multi  = multiplo;
    a.estado = db_estado;
    return a;
  endfunction

  function automatic void model_reset();
    m_hist = {};
    for (int k = 0; k < D + 2; k++) m_hist.push_back(7'd0);
    m_deb   = '0;
    m_key   = '0;
    m_state = 0;
  endfunction

  // One clock edge with the given inputs; expected outputs queued for the monitor.
  task automatic step(input logic [6:0] raw, input logic hab, input logic rst);
    out_t       e;
    int         pc;
    int         nxt;
    logic       pulse;
    logic [6:0] new_deb;
    bit         all_diff;
    @(negedge clock);
    botoes_raw = raw;
    habilita   = hab;
    reset      = rst;
    e = '0;
    if (!rst) begin
      model_reset();
    end else begin
      pc    = $countones(m_deb);
      nxt   = m_state;
      pulse = 1'b0;
      if (m_state == 0) begin
        if (pc == 1) nxt = 1;
        else if (pc >= 2) nxt = 2;
      end else if (m_state == 1) begin
        if (pc == 0) nxt = 0;
        else if (pc >= 2 || m_deb != m_key) nxt = 2;
      end else begin
        if (pc == 0) nxt = 0;
      end
      if (m_state == 0 && nxt == 1) begin
        m_key = m_deb;
        pulse = hab;
      end
      // A bit flips once its last D synchronized samples (raw taken 2..D+1 edges ago) all disagree.
      new_deb = m_deb;
      for (int i = 0; i < 7; i++) begin
        all_diff = 1;
        for (int k = 0; k < D; k++)
          if (m_hist[1 + k][i] == m_deb[i]) all_diff = 0;
        if (all_diff) new_deb[i] = ~m_deb[i];
      end
      m_hist.push_front(raw);
      void'(m_hist.pop_back());
      m_deb   = new_deb;
      m_state = nxt;
      if (nxt == 1) begin
        e.botoes = m_key;
        for (int i = 0; i < 7; i++) if (m_key[i]) e.nota = 3'(i + 1);
      end
      e.tem    = |m_deb;
      e.pulso  = pulse;
      e.multi  = (nxt == 2);
      e.estado = 2'(nxt);
    end
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic [6:0] raw, input logic hab, input int n);
    for (int c = 0; c < n; c++) step(raw, hab, 1'b1);
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock edge.
  task automatic mid_reset();
    out_t a;
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    a = actual();
    checks++;
    if (a !== out_t'(0)) begin
      errors++;
      $display("FAIL async_reset_clear got=%h required=%h", a, out_t'(0));
    end
    model_reset();
  endtask

  // Monitor: compares every edge for which an expectation was queued.
  initial begin
    out_t e;
    out_t a;
    while (!done) begin
      @(posedge clock);
      #1;
      cycle++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = actual();
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL scoreboard cycle=%0d got botoes=%b nota=%0d tem=%b pulso=%b multi=%b estado=%b required botoes=%b nota=%0d tem=%b pulso=%b multi=%b estado=%b",
                   cycle, a.botoes, a.nota, a.tem, a.pulso, a.multi, a.estado,
                   e.botoes, e.nota, e.tem, e.pulso, e.multi, e.estado);
        end
      end
    end
  end

  initial begin
    logic [6:0] p;
    int         r;
    int         len;
    logic       hab;
    model_reset();
    hold(7'd0, 1'b1, 0);
    for (int c = 0; c < 3; c++) step(7'd0, 1'b1, 1'b0);
    hold(7'd0, 1'b1, 2);

    // Single press of bit 2, then release.
    hold(7'b0000100, 1'b1, 12);
    hold(7'd0, 1'b1, 10);
    // Short glitch on bit 0.
    hold(7'b0000001, 1'b1, 3);
    hold(7'd0, 1'b1, 10);
    // Multi-press: bit 1, add bit 5, drop bit 5, drop all.
    hold(7'b0000010, 1'b1, 10);
    hold(7'b0100010, 1'b1, 10);
    hold(7'b0000010, 1'b1, 10);
    hold(7'd0, 1'b1, 10);
    // Press with pulses disabled.
    hold(7'b0010000, 1'b0, 10);
    hold(7'd0, 1'b0, 10);
    // Reset during a held press, release with bit 6 held.
    hold(7'b1000000, 1'b1, 10);
    mid_reset();
    for (int c = 0; c < 3; c++) step(7'b1000000, 1'b1, 1'b0);
    hold(7'b1000000, 1'b1, 12);
    hold(7'd0, 1'b1, 10);
    // Press, release, press again on bit 3.
    hold(7'b0001000, 1'b1, 8);
    hold(7'd0, 1'b1, 8);
    hold(7'b0001000, 1'b1, 8);
    hold(7'd0, 1'b1, 8);
    // Reset asserted during the pulse cycle.
    hold(7'b0000001, 1'b1, 7);
    mid_reset();
    step(7'b0000000, 1'b1, 1'b0);
    hold(7'd0, 1'b1, 10);

    for (int s = 0; s < 90; s++) begin
      r   = $urandom_range(0, 99);
      len = $urandom_range(1, 12);
      hab = ($urandom_range(0, 3) != 0);
      if (r < 60)      p = 7'(1 << $urandom_range(0, 6));
      else if (r < 75) p = 7'd0;
      else if (r < 90) p = 7'(1 << $urandom_range(0, 6)) | 7'(1 << $urandom_range(0, 6));
      else             p = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 19) == 0) begin
        mid_reset();
        step(p, hab, 1'b0);
      end
      hold(p, hab, len);
    end
    hold(7'd0, 1'b1, 12);

    @(negedge clock);
    @(negedge clock);
    done = 1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
